mp_operand_loader: RTL and testbench



---
 rtl/mp_operand_loader_pkg.sv | 33 +++
 rtl/mp_operand_loader_serializer.sv | 57 +++++
 rtl/mp_operand_loader.sv | 107 ++++++++++
 tb/tb_mp_operand_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mp_operand_loader_pkg.sv
// Shared constants, state encoding and sizing helpers for the mp_adder front-end.
// Word counts are derived from the operand and word widths.
package mp_pkg;

  localparam int OPERAND_WIDTH_DEF = 128;
  localparam int WORD_WIDTH_DEF    = 32;

  function automatic int calcNOp(input int opW, input int wordW);
    return opW / wordW;
  endfunction

  // The carry makes the result one bit wider, so its word count rounds up.
  function automatic int calcNRes(input int opW, input int wordW);
    return (opW + wordW) / wordW;
  endfunction

  function automatic int calcCntW(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int N_OP  = calcNOp(OPERAND_WIDTH_DEF, WORD_WIDTH_DEF);
  localparam int N_RES = calcNRes(OPERAND_WIDTH_DEF, WORD_WIDTH_DEF);
  localparam int CNT_W = calcCntW(N_RES);

  typedef enum logic [2:0] {
    LOAD_A    = 3'd0,
    LOAD_B    = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    SEND      = 3'd4
  } loaderState_t;

endpackage

// File: rtl/mp_operand_loader_serializer.sv
// mp_result_serializer: captures a wide result and streams it out LS word first
// on a valid/ready handshake; oLast flags the final transfer.
module mp_result_serializer
  import mp_pkg::*;
#(
  parameter int RES_W      = 129,
  parameter int WORD_WIDTH = 32,
  parameter int N_RES      = 5
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iLoad,
  input  logic [RES_W-1:0]      iRes,
  input  logic                  iOutReady,
  output logic                  oOutValid,
  output logic [WORD_WIDTH-1:0] oOutWord,
  output logic                  oLast
);

  localparam int CNT_W_L = calcCntW(N_RES);
  localparam int PAD_W   = N_RES * WORD_WIDTH;

  logic [PAD_W-1:0]   resReg;
  logic [CNT_W_L-1:0] cnt;
  logic               xfer;

  function automatic logic [WORD_WIDTH-1:0] wordAt(input logic [PAD_W-1:0] v, input int idx);
    return v[idx*WORD_WIDTH +: WORD_WIDTH];
  endfunction

  assign xfer  = oOutValid && iOutReady;
  assign oLast = xfer && (cnt == CNT_W_L'(N_RES - 1));

  // The next word is registered ahead so it is valid alongside oOutValid.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      resReg    <= '0;
      cnt       <= '0;
      oOutValid <= 1'b0;
      oOutWord  <= '0;
    end else if (iLoad) begin
      resReg    <= PAD_W'(iRes);
      cnt       <= '0;
      oOutValid <= 1'b1;
      oOutWord  <= iRes[WORD_WIDTH-1:0];
    end else if (xfer) begin
      if (oLast) begin
        cnt       <= '0;
        oOutValid <= 1'b0;
      end else begin
        cnt      <= cnt + 1'b1;
        oOutWord <= wordAt(resReg, int'(cnt) + 1);
      end
    end
  end

endmodule

// File: rtl/mp_operand_loader.sv
// Word-stream front-end for mp_adder: loads A then B, pulses start, returns the sum.
// Define MP_LOADER_TIMEOUT_EN to add a WAIT_DONE watchdog driving oTimeout.
module mp_operand_loader
  import mp_pkg::*;
#(
  parameter int OPERAND_WIDTH  = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iInValid,
  input  logic [WORD_WIDTH-1:0]    iInWord,
  output logic                     oInReady,
  output logic                     oStart,
  output logic [OPERAND_WIDTH-1:0] oOpA,
  output logic [OPERAND_WIDTH-1:0] oOpB,
  input  logic [OPERAND_WIDTH:0]   iRes,
  input  logic                     iDone,
  output logic                     oOutValid,
  output logic [WORD_WIDTH-1:0]    oOutWord,
  input  logic                     iOutReady,
  output logic                     oTimeout
);

  localparam int nOp  = calcNOp(OPERAND_WIDTH, WORD_WIDTH);
  localparam int nRes = calcNRes(OPERAND_WIDTH, WORD_WIDTH);
  localparam int cntW = calcCntW(nRes);

  loaderState_t     state, nextState;
  logic [cntW-1:0]  loadCnt;
  logic             inXfer, lastIn, capture, sendLast, wdExpire;

  assign inXfer  = iInValid && oInReady;
  assign lastIn  = inXfer && (loadCnt == cntW'(nOp - 1));
  assign capture = (state == WAIT_DONE) && iDone;

`ifdef MP_LOADER_TIMEOUT_EN
  localparam int wdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [wdW-1:0] wdCnt;

  // Held at zero outside WAIT_DONE, so every entry starts a fresh count.
  always_ff @(posedge iClk) begin
    if (iRst || state != WAIT_DONE) wdCnt <= '0;
    else if (wdCnt != wdW'(TIMEOUT_CYCLES - 1)) wdCnt <= wdCnt + 1'b1;
  end

  assign wdExpire = (state == WAIT_DONE) && !iDone && (wdCnt == wdW'(TIMEOUT_CYCLES - 1));
`else
  assign wdExpire = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (iRst) state <= LOAD_A;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      LOAD_A:    if (lastIn) nextState = LOAD_B;
      LOAD_B:    if (lastIn) nextState = START;
      START:     nextState = WAIT_DONE;
      WAIT_DONE: begin
        if (capture)       nextState = SEND;
        else if (wdExpire) nextState = LOAD_A;
      end
      SEND:      if (sendLast) nextState = LOAD_A;
      default:   nextState = LOAD_A;
    endcase
  end

  always_comb begin
    oInReady = (state == LOAD_A) || (state == LOAD_B);
    oStart   = (state == START);
    oTimeout = wdExpire;
  end

  // Operands only change during their load state, so they stay put through the add.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      loadCnt <= '0;
      oOpA    <= '0;
      oOpB    <= '0;
    end else if (inXfer) begin
      if (state == LOAD_A) oOpA[int'(loadCnt)*WORD_WIDTH +: WORD_WIDTH] <= iInWord;
      else                 oOpB[int'(loadCnt)*WORD_WIDTH +: WORD_WIDTH] <= iInWord;
      loadCnt <= lastIn ? '0 : loadCnt + 1'b1;
    end
  end

  mp_result_serializer #(
    .RES_W      (OPERAND_WIDTH + 1),
    .WORD_WIDTH (WORD_WIDTH),
    .N_RES      (nRes)
  ) uSer (
    .iClk      (iClk),
    .iRst      (iRst),
    .iLoad     (capture),
    .iRes      (iRes),
    .iOutReady (iOutReady),
    .oOutValid (oOutValid),
    .oOutWord  (oOutWord),
    .oLast     (sendLast)
  );

endmodule

// File: tb/tb_mp_operand_loader.sv
// Scoreboard bench for mp_operand_loader with a behavioural mp_adder (3-cycle latency).
// Build with MP_LOADER_TIMEOUT_EN to also exercise the watchdog.
module tb_mp_operand_loader;

  logic         clk = 1'b0;
  logic         iRst, iInValid, iDone, iOutReady;
  logic [31:0]  iInWord;
  logic         oInReady, oStart, oOutValid, oTimeout;
  logic [127:0] oOpA, oOpB;
  logic [128:0] iRes;
  logic [31:0]  oOutWord;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accCnt = 0, xfersOp = 0, totalX = 0, startCnt = 0, startCyc = 0;
  logic [31:0]  expQ[$];
  logic [255:0] opQ[$];
  logic         stallEn = 1'b0, stallPrev = 1'b0, holdDone = 1'b0;
  int           stallCnt = 0;
  logic [31:0]  prevWord;
  int           addCnt = 0;

  mp_operand_loader #(
    .OPERAND_WIDTH(128), .WORD_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .iClk(clk), .iRst(iRst), .iInValid(iInValid), .iInWord(iInWord),
    .oInReady(oInReady), .oStart(oStart), .oOpA(oOpA), .oOpB(oOpB),
    .iRes(iRes), .iDone(iDone), .oOutValid(oOutValid), .oOutWord(oOutWord),
    .iOutReady(iOutReady), .oTimeout(oTimeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Behavioural adder: sum latched on start, done one cycle after 3 cycles.
  always @(posedge clk) begin
    iDone <= 1'b0;
    if (iRst) addCnt <= 0;
    else if (oStart) begin
      iRes   <= {1'b0, oOpA} + {1'b0, oOpB};
      addCnt <= 3;
    end else if (addCnt > 0) begin
      addCnt <= addCnt - 1;
      if (addCnt == 1 && !holdDone) iDone <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (iRst) begin
      accCnt    = 0;
      stallPrev = 1'b0;
    end else begin
      if (iInValid && oInReady) accCnt++;
      if (oStart) begin
        startCnt++;
        startCyc = cyc;
        chk("startAfter8", accCnt, 8);
        chk("opQueued", opQ.size() > 0, 1);
        if (opQ.size() > 0) begin
          logic [255:0] ab;
          ab = opQ.pop_front();
          chk("opA", oOpA, ab[255:128]);
          chk("opB", oOpB, ab[127:0]);
        end
        accCnt  = 0;
        xfersOp = 0;
      end
      if (stallPrev) begin
        chk("stallValid", oOutValid, 1);
        chk("stallWord", oOutWord, prevWord);
      end
      stallPrev = oOutValid && !iOutReady;
      prevWord  = oOutWord;
      if (oOutValid && iOutReady) begin
        xfersOp++;
        totalX++;
        chk("wordExpected", expQ.size() > 0, 1);
        if (expQ.size() > 0) chk("outWord", oOutWord, expQ.pop_front());
      end
    end
  end

  initial begin
    iOutReady = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stallEn && xfersOp == 2 && stallCnt < 3) begin
        iOutReady = 1'b0;
        stallCnt++;
      end else iOutReady = 1'b1;
    end
  end

  task automatic pushWord(input logic [31:0] w, input bit gap);
    logic rdy;
    int n;
    iInValid = 1'b1;
    iInWord  = w;
    n = 0;
    do begin
      @(negedge clk); rdy = oInReady;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 300);
    if (!rdy) chk("inAcceptTimeout", n, 0);
    iInValid = 1'b0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic runOp(input logic [127:0] a, input logic [127:0] b, input bit gap);
    opQ.push_back({a, b});
    for (int i = 0; i < 4; i++) pushWord(a[i*32 +: 32], gap);
    for (int i = 0; i < 4; i++) pushWord(b[i*32 +: 32], gap);
  endtask

  task automatic expectSum(input logic [127:0] a, input logic [127:0] b);
    logic [159:0] s;
    s = 160'({1'b0, a} + {1'b0, b});
    for (int i = 0; i < 5; i++) expQ.push_back(s[i*32 +: 32]);
  endtask

  task automatic expectWords(input logic [159:0] ws);
    for (int i = 0; i < 5; i++) expQ.push_back(ws[i*32 +: 32]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 500) begin @(posedge clk); n++; end
    chk("drained", expQ.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [127:0] bA, bB, ones, rA, rB;
  int s0, x0, n;

  initial begin
    bA   = 128'h12121212_34343434_56565656_78787878;
    bB   = 128'hefefefef_cdcdcdcd_abababab_90909090;
    ones = '1;
    iRst = 1'b1; iInValid = 1'b0; iInWord = '0;
    repeat (3) @(posedge clk);
    #1 iRst = 1'b0;
    chk("rstReady", oInReady, 1);
    chk("rstStart", oStart, 0);
    chk("rstOutValid", oOutValid, 0);
    chk("rstOutWord", oOutWord, 0);
    chk("rstTimeout", oTimeout, 0);
    chk("rstOpA", oOpA, 0);

    // Basic add, contiguous load
    s0 = startCnt;
    expectWords({32'h00000001, 32'h02020202, 32'h02020202, 32'h02020202, 32'h09090908});
    runOp(bA, bB, 1'b0);
    drain();
    chk("oneStart", startCnt - s0, 1);

    // Same operands with gapped input
    s0 = startCnt;
    expectWords({32'h00000001, 32'h02020202, 32'h02020202, 32'h02020202, 32'h09090908});
    runOp(bA, bB, 1'b1);
    drain();
    chk("oneStartGap", startCnt - s0, 1);

    // Output backpressure in the middle of SEND
    rA = {$urandom, $urandom, $urandom, $urandom};
    rB = {$urandom, $urandom, $urandom, $urandom};
    stallCnt = 0; stallEn = 1'b1;
    expectSum(rA, rB);
    runOp(rA, rB, 1'b0);
    drain();
    stallEn = 1'b0;
    chk("stallCycles", stallCnt, 3);
    chk("xfersStall", xfersOp, 5);

    // Reset after two B words discards everything
    for (int i = 0; i < 4; i++) pushWord(32'hA5A50000 + i, 1'b0);
    pushWord(32'h11111111, 1'b0);
    pushWord(32'h22222222, 1'b0);
    iRst = 1'b1;
    @(posedge clk); #1 iRst = 1'b0;
    chk("midRstReady", oInReady, 1);
    chk("midRstOpA", oOpA, 0);
    chk("midRstOpB", oOpB, 0);
    chk("midRstOutValid", oOutValid, 0);
    expectWords({32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
    runOp('0, ones, 1'b0);
    drain();

    // Back-to-back: second load queued right behind the first result
    expectSum(bB, rA);
    expectWords({32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    runOp(bB, rA, 1'b0);
    runOp(ones, ones, 1'b0);
    drain();
    chk("noTimeout", oTimeout, 0);

`ifdef MP_LOADER_TIMEOUT_EN
    holdDone = 1'b1;
    x0 = totalX;
    runOp(bA, bB, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!oTimeout && n < 100);
    chk("timeoutSeen", oTimeout, 1);
    chk("timeoutDelay", cyc - startCyc, 16);
    @(negedge clk);
    chk("timeoutOnce", oTimeout, 0);
    chk("readyAfterTimeout", oInReady, 1);
    chk("opAKept", oOpA, bA);
    repeat (10) @(posedge clk);
    chk("noOutputAfterTimeout", totalX, x0);
    holdDone = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL globalTimeout got %0d want %0d", cyc, 0);
    $fatal(1, "bench timed out");
  end

endmodule
